// File: rtl/bbox_raster_walker_if.sv
// Triangle-in / pixel-out bundle between the raster set-up stage, the bounding-box walker
// and the downstream edge-function tester.
interface bbox_raster_walker_if #(
    parameter int COORD_W  = 32,
    parameter int SCREEN_W = 32
);
    logic                  tri_valid;
    logic                  tri_ready;
    logic [2*COORD_W-1:0]  pa;
    logic [2*COORD_W-1:0]  pb;
    logic [2*COORD_W-1:0]  pc;
    logic [SCREEN_W-1:0]   resx;
    logic [SCREEN_W-1:0]   resy;
    logic                  bb_valid;
    logic [SCREEN_W-1:0]   bb_left;
    logic [SCREEN_W-1:0]   bb_right;
    logic [SCREEN_W-1:0]   bb_top;
    logic [SCREEN_W-1:0]   bb_bottom;
    logic                  pix_valid;
    logic                  pix_ready;
    logic [SCREEN_W-1:0]   pix_x;
    logic [SCREEN_W-1:0]   pix_y;
    logic                  pix_last;
    logic                  tri_done;

    modport master (
        output tri_valid, pa, pb, pc, resx, resy, pix_ready,
        input  tri_ready, bb_valid, bb_left, bb_right, bb_top, bb_bottom,
               pix_valid, pix_x, pix_y, pix_last, tri_done
    );

    modport slave (
        input  tri_valid, pa, pb, pc, resx, resy, pix_ready,
        output tri_ready, bb_valid, bb_left, bb_right, bb_top, bb_bottom,
               pix_valid, pix_x, pix_y, pix_last, tri_done
    );
endinterface

// File: rtl/bbox_raster_walker.sv
// Computes the screen-clamped half-open bounding box of one fixed-point triangle and walks it
// row-major, one pixel (or one 2x2 quad) per downstream handshake.
module bbox_raster_walker #(
    parameter int COORD_W  = 32,
    parameter int FRAC_W   = 8,
    parameter int SCREEN_W = 32,
    parameter int QUAD     = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bbox_raster_walker_if.slave   bus
);
    localparam int CW = COORD_W + 1;
    localparam int EW = (CW > SCREEN_W + 1) ? CW : SCREEN_W + 1;
    localparam logic [SCREEN_W:0] STEP = (QUAD != 0) ? (SCREEN_W+1)'(2) : (SCREEN_W+1)'(1);

    typedef enum logic [1:0] {IDLE, CALC, WALK} state_t;

    function automatic logic signed [COORD_W-1:0] min3(input logic signed [COORD_W-1:0] a,
                                                        input logic signed [COORD_W-1:0] b,
                                                        input logic signed [COORD_W-1:0] c);
        logic signed [COORD_W-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic signed [COORD_W-1:0] max3(input logic signed [COORD_W-1:0] a,
                                                        input logic signed [COORD_W-1:0] b,
                                                        input logic signed [COORD_W-1:0] c);
        logic signed [COORD_W-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic logic signed [CW-1:0] floor_fx(input logic signed [COORD_W-1:0] v);
        logic signed [CW-1:0] e;
        e = CW'(v);
        return e >>> FRAC_W;
    endfunction

    // One extra bit keeps the round-up bias from overflowing near the top of the range.
    function automatic logic signed [CW-1:0] ceil_fx(input logic signed [COORD_W-1:0] v);
        logic signed [CW-1:0] e;
        logic signed [CW-1:0] bias;
        bias = CW'((1 << FRAC_W) - 1);
        e    = CW'(v) + bias;
        return e >>> FRAC_W;
    endfunction

    function automatic logic [SCREEN_W-1:0] clamp_res(input logic signed [CW-1:0] v,
                                                      input logic [SCREEN_W-1:0] res);
        logic signed [EW-1:0] ve;
        logic signed [EW-1:0] re;
        ve = EW'(v);
        re = $signed(EW'(res));
        if (ve < 0)
            return '0;
        else if (ve > re)
            return res;
        else
            return SCREEN_W'(ve);
    endfunction

    function automatic logic [SCREEN_W-1:0] align_q(input logic [SCREEN_W-1:0] v);
        if (QUAD != 0)
            return v & ~SCREEN_W'(1);
        return v;
    endfunction

    state_t state, state_nxt;

    logic signed [COORD_W-1:0] ax_p0, ay_p0, bx_p0, by_p0, cx_p0, cy_p0;
    logic [SCREEN_W-1:0]       resx_p0, resy_p0;

    logic [SCREEN_W-1:0] l_c, r_c, t_c, b_c;
    logic                empty_c;

    logic                ready_en;
    logic                bb_valid_q;
    logic [SCREEN_W-1:0] bb_l_q, bb_r_q, bb_t_q, bb_b_q;
    logic [SCREEN_W-1:0] x_q, y_q;
    logic                done_q;

    logic accept, hs, done_nxt;
    logic row_end, col_end, pix_last_c, tri_ready_c;

    // Stage 0: vertex/resolution capture on accept
    always_ff @(posedge clk) begin
        if (accept) begin
            ax_p0   <= bus.pa[2*COORD_W-1:COORD_W];
            ay_p0   <= bus.pa[COORD_W-1:0];
            bx_p0   <= bus.pb[2*COORD_W-1:COORD_W];
            by_p0   <= bus.pb[COORD_W-1:0];
            cx_p0   <= bus.pc[2*COORD_W-1:COORD_W];
            cy_p0   <= bus.pc[COORD_W-1:0];
            resx_p0 <= bus.resx;
            resy_p0 <= bus.resy;
        end
    end

    // Stage 1: box arithmetic, evaluated during CALC
    assign l_c     = clamp_res(floor_fx(min3(ax_p0, bx_p0, cx_p0)), resx_p0);
    assign r_c     = clamp_res(ceil_fx(max3(ax_p0, bx_p0, cx_p0)),  resx_p0);
    assign t_c     = clamp_res(floor_fx(min3(ay_p0, by_p0, cy_p0)), resy_p0);
    assign b_c     = clamp_res(ceil_fx(max3(ay_p0, by_p0, cy_p0)),  resy_p0);
    assign empty_c = (l_c >= r_c) || (t_c >= b_c);

    assign row_end     = ({1'b0, x_q} + STEP) >= {1'b0, bb_r_q};
    assign col_end     = ({1'b0, y_q} + STEP) >= {1'b0, bb_b_q};
    assign pix_last_c  = (state == WALK) && row_end && col_end;
    // ready_en keeps tri_ready low while reset is held even though state already reads IDLE.
    assign tri_ready_c = (state == IDLE) && ready_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        hs        = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.tri_valid && tri_ready_c) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (empty_c) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = WALK;
                end
            end
            WALK: begin
                if (bus.pix_ready) begin
                    hs = 1'b1;
                    if (pix_last_c) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage 2: registered box and walk position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en   <= 1'b0;
            bb_valid_q <= 1'b0;
            bb_l_q     <= '0;
            bb_r_q     <= '0;
            bb_t_q     <= '0;
            bb_b_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            done_q     <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            done_q   <= done_nxt;
            if (accept)
                bb_valid_q <= 1'b0;
            if (state == CALC) begin
                bb_valid_q <= 1'b1;
                bb_l_q     <= l_c;
                bb_r_q     <= r_c;
                bb_t_q     <= t_c;
                bb_b_q     <= b_c;
                if (!empty_c) begin
                    x_q <= align_q(l_c);
                    y_q <= align_q(t_c);
                end
            end
            if (hs) begin
                if (row_end) begin
                    x_q <= align_q(bb_l_q);
                    y_q <= y_q + STEP[SCREEN_W-1:0];
                end else begin
                    x_q <= x_q + STEP[SCREEN_W-1:0];
                end
            end
        end
    end

    assign bus.tri_ready = tri_ready_c;
    assign bus.bb_valid  = bb_valid_q;
    assign bus.bb_left   = bb_l_q;
    assign bus.bb_right  = bb_r_q;
    assign bus.bb_top    = bb_t_q;
    assign bus.bb_bottom = bb_b_q;
    assign bus.pix_valid = (state == WALK);
    assign bus.pix_x     = x_q;
    assign bus.pix_y     = y_q;
    assign bus.pix_last  = pix_last_c;
    assign bus.tri_done  = done_q;
endmodule

// File: tb/tb_bbox_raster_walker.sv
// Directed bench for bbox_raster_walker: a pixel-mode and a quad-mode instance share stimulus,
// one of them selected at a time.
module tb_bbox_raster_walker;
    localparam int CW = 32;
    localparam int FW = 8;
    localparam int SW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          sel;
    logic          tri_valid, pix_ready;
    logic [63:0]   pa, pb, pc;
    logic [31:0]   resx, resy;
    int            checks = 0;
    int            errors = 0;

    bbox_raster_walker_if #(.COORD_W(CW), .SCREEN_W(SW)) if0 ();
    bbox_raster_walker_if #(.COORD_W(CW), .SCREEN_W(SW)) if1 ();

    assign if0.tri_valid = tri_valid & ~sel;
    assign if1.tri_valid = tri_valid & sel;
    assign if0.pix_ready = pix_ready;
    assign if1.pix_ready = pix_ready;
    assign if0.pa = pa;   assign if1.pa = pa;
    assign if0.pb = pb;   assign if1.pb = pb;
    assign if0.pc = pc;   assign if1.pc = pc;
    assign if0.resx = resx; assign if1.resx = resx;
    assign if0.resy = resy; assign if1.resy = resy;

    logic        o_tri_ready, o_bb_valid, o_pix_valid, o_pix_last, o_tri_done;
    logic [31:0] o_l, o_r, o_t, o_b, o_x, o_y;
    assign o_tri_ready = sel ? if1.tri_ready : if0.tri_ready;
    assign o_bb_valid  = sel ? if1.bb_valid  : if0.bb_valid;
    assign o_pix_valid = sel ? if1.pix_valid : if0.pix_valid;
    assign o_pix_last  = sel ? if1.pix_last  : if0.pix_last;
    assign o_tri_done  = sel ? if1.tri_done  : if0.tri_done;
    assign o_l = sel ? if1.bb_left   : if0.bb_left;
    assign o_r = sel ? if1.bb_right  : if0.bb_right;
    assign o_t = sel ? if1.bb_top    : if0.bb_top;
    assign o_b = sel ? if1.bb_bottom : if0.bb_bottom;
    assign o_x = sel ? if1.pix_x     : if0.pix_x;
    assign o_y = sel ? if1.pix_y     : if0.pix_y;

    bbox_raster_walker #(.COORD_W(CW), .FRAC_W(FW), .SCREEN_W(SW), .QUAD(0)) u_pix (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave)
    );
    bbox_raster_walker #(.COORD_W(CW), .FRAC_W(FW), .SCREEN_W(SW), .QUAD(1)) u_quad (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] vtx(input int x_fx, input int y_fx);
        return {x_fx[31:0], y_fx[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one triangle, then step through CALC; returns in the cycle after CALC.
    task automatic give_tri(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                            input logic [31:0] rx, input logic [31:0] ry);
        pa = a; pb = b; pc = c; resx = rx; resy = ry;
        tri_valid = 1'b1;
        check("accept_ready", o_tri_ready, 1);
        tick();
        tri_valid = 1'b0;
        check("calc_bb_valid", o_bb_valid, 0);
        check("calc_pix_valid", o_pix_valid, 0);
        tick();
    endtask

    task automatic check_box(input int l, input int r, input int t, input int b);
        check("bb_valid", o_bb_valid, 1);
        check("bb_left", o_l, l);
        check("bb_right", o_r, r);
        check("bb_top", o_t, t);
        check("bb_bottom", o_b, b);
    endtask

    task automatic walk(input int l, input int r, input int t, input int b, input int step,
                        input bit rnd, input int max_pix, output int n);
        int x, y, cyc;
        bit done, last;
        x = (step == 2) ? (l & ~1) : l;
        y = (step == 2) ? (t & ~1) : t;
        n = 0; cyc = 0; done = 0;
        while (!done && n < max_pix && cyc < 20000) begin
            pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            last = (x + step >= r) && (y + step >= b);
            check("pix_valid", o_pix_valid, 1);
            check("pix_x", o_x, x);
            check("pix_y", o_y, y);
            check("pix_last", o_pix_last, last);
            if (pix_ready) begin
                n++;
                if (last) done = 1;
                if (x + step >= r) begin
                    x = (step == 2) ? (l & ~1) : l;
                    y = y + step;
                end else begin
                    x = x + step;
                end
            end
            tick();
            cyc++;
        end
        if (cyc >= 20000)
            check("walk_cycle_bound", cyc, 0);
    endtask

    int n;

    initial begin
        sel = 1'b0; tri_valid = 1'b0; pix_ready = 1'b0;
        pa = '0; pb = '0; pc = '0; resx = 32'd1920; resy = 32'd1080;

        // Reset state
        rst_n = 1'b0;
        tick(); tick();
        check("rst_tri_ready", o_tri_ready, 0);
        check("rst_bb_valid", o_bb_valid, 0);
        check("rst_pix_valid", o_pix_valid, 0);
        check("rst_tri_done", o_tri_done, 0);
        check("rst_pix_x", o_x, 0);
        check("rst_bb_right", o_r, 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_tri_ready", o_tri_ready, 1);

        // Test 1: generic triangle, full-rate walk
        give_tri(vtx(1254, 1223), vtx(2457, 4761), vtx(3225, 332), 1920, 1080);
        check_box(4, 13, 1, 19);
        walk(4, 13, 1, 19, 1, 0, 100000, n);
        check("t1_pixels", n, 162);
        check("t1_tri_done", o_tri_done, 1);
        check("t1_tri_ready", o_tri_ready, 1);
        check("t1_pix_valid_end", o_pix_valid, 0);
        check("t1_bb_valid_hold", o_bb_valid, 1);
        tick();
        check("t1_done_pulse", o_tri_done, 0);

        // Test 3: small box, random backpressure
        give_tri(vtx(128, 128), vtx(640, 128), vtx(128, 384), 1920, 1080);
        check_box(0, 3, 0, 2);
        walk(0, 3, 0, 2, 1, 1, 100000, n);
        check("t3_pixels", n, 6);
        check("t3_tri_done", o_tri_done, 1);
        tick();

        // Test 4: box entirely right of screen
        give_tri(vtx(2001*256, 5*256), vtx(2010*256, 6*256), vtx(2005*256, 10*256), 1920, 1080);
        check_box(1920, 1920, 5, 10);
        check("t4_pix_valid", o_pix_valid, 0);
        check("t4_tri_done", o_tri_done, 1);
        check("t4_tri_ready", o_tri_ready, 1);
        tick();
        check("t4_done_pulse", o_tri_done, 0);
        check("t4_pix_valid_after", o_pix_valid, 0);

        // Zero resolution yields an empty box
        give_tri(vtx(1254, 1223), vtx(2457, 4761), vtx(3225, 332), 0, 1080);
        check_box(0, 0, 1, 19);
        check("res0_tri_done", o_tri_done, 1);
        check("res0_pix_valid", o_pix_valid, 0);
        tick();

        // Test 5: quad mode
        sel = 1'b1;
        give_tri(vtx(819, 384), vtx(1664, 998), vtx(896, 768), 1920, 1080);
        check_box(3, 7, 1, 4);
        walk(3, 7, 1, 4, 2, 0, 100000, n);
        check("t5_quads", n, 6);
        check("t5_tri_done", o_tri_done, 1);
        tick();
        sel = 1'b0;

        // Test 6: back-to-back triangles with tri_valid held high
        pa = vtx(128, 128); pb = vtx(640, 128); pc = vtx(128, 384);
        tri_valid = 1'b1;
        check("t6_accept1", o_tri_ready, 1);
        tick();
        pa = vtx(819, 384); pb = vtx(1664, 998); pc = vtx(896, 768);
        tick();
        check_box(0, 3, 0, 2);
        walk(0, 3, 0, 2, 1, 0, 100000, n);
        check("t6_pixels1", n, 6);
        check("t6_done1", o_tri_done, 1);
        check("t6_ready_in_done", o_tri_ready, 1);
        tick();
        tri_valid = 1'b0;
        check("t6_accept2_bb_cleared", o_bb_valid, 0);
        tick();
        check_box(3, 7, 1, 4);
        walk(3, 7, 1, 4, 1, 0, 100000, n);
        check("t6_pixels2", n, 12);
        check("t6_done2", o_tri_done, 1);
        tick();

        // Test 2: clamped box, abort by reset after the first row
        give_tri(vtx(-1871, 1223), vtx(2457, 2635225), vtx(500403, 332), 1920, 1080);
        check_box(0, 1920, 1, 1080);
        walk(0, 1920, 1, 1080, 1, 0, 1920, n);
        check("t2_row_pixels", n, 1920);
        check("t2_pix_valid", o_pix_valid, 1);
        check("t2_pix_x_row2", o_x, 0);
        check("t2_pix_y_row2", o_y, 2);
        rst_n = 1'b0;
        #1;
        check("t2_rst_tri_ready", o_tri_ready, 0);
        check("t2_rst_bb_valid", o_bb_valid, 0);
        check("t2_rst_bb_left", o_l, 0);
        check("t2_rst_bb_right", o_r, 0);
        check("t2_rst_bb_top", o_t, 0);
        check("t2_rst_bb_bottom", o_b, 0);
        check("t2_rst_pix_valid", o_pix_valid, 0);
        check("t2_rst_pix_x", o_x, 0);
        check("t2_rst_pix_y", o_y, 0);
        check("t2_rst_pix_last", o_pix_last, 0);
        check("t2_rst_tri_done", o_tri_done, 0);
        tick(); tick();
        check("t2_rst_done_held", o_tri_done, 0);
        rst_n = 1'b1;
        tick();
        check("t2_post_done", o_tri_done, 0);
        check("t2_post_ready", o_tri_ready, 1);
        check("t2_post_pix_valid", o_pix_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
